// File: rtl/press_referee.sv
// rtl/press_referee.sv - reaction-round controller and single-winner press arbiter
// Optional feature macro: PRESS_REFEREE_RANDOM_DELAY_EN (adds lfsr[2:0] extra hold-off cycles)

module press_referee #(
   parameter int N_PLAYERS      = 2,
   parameter int DELAY_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic                 Clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [N_PLAYERS-1:0] press,
   output logic                 go,
   output logic                 busy,
   output logic [N_PLAYERS-1:0] winner,
   output logic [N_PLAYERS-1:0] foul,
   output logic                 timeout,
   output logic                 round_done
);

   localparam int PTR_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      GO     = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_next;
   logic [CNT_W-1:0]     hold_load;
   logic [N_PLAYERS-1:0] winner_next;
   logic [N_PLAYERS-1:0] foul_next;
   logic                 timeout_next;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     ptr_next;
   logic [PTR_W-1:0]     cand;
   logic [PTR_W-1:0]     pick_idx;
   logic                 pick_found;

`ifdef PRESS_REFEREE_RANDOM_DELAY_EN
   logic [7:0] lfsr;

   // Free-running LFSR (taps 8,6,5,4); its low bits randomise the hold-off at the accepting start
   always_ff @(posedge Clock) begin
      if (reset)
         lfsr <= 8'h01;
      else
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign hold_load = CNT_W'(DELAY_CYCLES - 1) + CNT_W'(lfsr[2:0]);
`else
   assign hold_load = CNT_W'(DELAY_CYCLES - 1);
`endif

   // Round-robin search: first pressed player at or above the pointer, wrapping around
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N_PLAYERS; k++) begin
         cand = PTR_W'((int'(ptr) + k) % N_PLAYERS);
         if (!pick_found && press[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and next-result logic; results stay put unless a round changes them
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      winner_next  = winner;
      foul_next    = foul;
      timeout_next = timeout;
      ptr_next     = ptr;
      case (state)
         IDLE: begin
            // a press in the same cycle as start is deliberately ignored
            if (start) begin
               state_next   = WAIT;
               cnt_next     = hold_load;
               winner_next  = '0;
               foul_next    = '0;
               timeout_next = 1'b0;
            end
         end
         WAIT: begin
            if (|press) begin
               foul_next  = press;
               state_next = RESULT;
            end else if (cnt == '0) begin
               state_next = GO;
               cnt_next   = CNT_W'(TIMEOUT_CYCLES - 1);
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         GO: begin
            // a press on the last GO cycle still wins over the timeout
            if (pick_found) begin
               winner_next = N_PLAYERS'(1) << pick_idx;
               ptr_next    = (pick_idx == PTR_W'(N_PLAYERS - 1)) ? '0 : pick_idx + 1'b1;
               state_next  = RESULT;
            end else if (cnt == '0) begin
               timeout_next = 1'b1;
               state_next   = RESULT;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RESULT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counter, results and fairness pointer registers
   always_ff @(posedge Clock) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         winner  <= '0;
         foul    <= '0;
         timeout <= 1'b0;
         ptr     <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         winner  <= winner_next;
         foul    <= foul_next;
         timeout <= timeout_next;
         ptr     <= ptr_next;
      end
   end

   assign go         = (state == GO);
   assign busy       = (state != IDLE);
   assign round_done = (state == RESULT);

endmodule

// File: tb/tb_press_referee.sv
// tb/tb_press_referee.sv - self-checking bench for press_referee (round table plus scoreboard)

module tb_press_referee;

   localparam int N = 2;
   localparam int D = 8;
   localparam int T = 64;

   logic         Clock = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] press;
   logic         go;
   logic         busy;
   logic [N-1:0] winner;
   logic [N-1:0] foul;
   logic         timeout;
   logic         round_done;

   int n_checks = 0;
   int n_fail   = 0;
   int fg;

   typedef struct {
      bit           in_go;
      int           off;
      logic [N-1:0] pv;
      bit           hold_start;
      logic [N-1:0] exp_win;
      logic [N-1:0] exp_foul;
      bit           exp_to;
      int           exp_go;
   } vec_t;

   typedef struct {
      logic [N-1:0] win;
      logic [N-1:0] foul;
      logic         to;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[11];
   logic [7:0] lfsr_m;

   always #5 Clock = ~Clock;

   press_referee #(
      .N_PLAYERS(N),
      .DELAY_CYCLES(D),
      .TIMEOUT_CYCLES(T),
      .CNT_W(8)
   ) dut (
      .Clock(Clock),
      .reset(reset),
      .start(start),
      .press(press),
      .go(go),
      .busy(busy),
      .winner(winner),
      .foul(foul),
      .timeout(timeout),
      .round_done(round_done)
   );

   always @(posedge Clock) begin
      if (reset)
         lfsr_m <= 8'h01;
      else
         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge Clock) begin
      if (!reset && round_done) begin
         if (sb.size() == 0) begin
            chk("unexpected_round_done", 32'(round_done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_winner", 32'(winner), 32'(mon_e.win));
            chk("sb_foul", 32'(foul), 32'(mon_e.foul));
            chk("sb_timeout", 32'(timeout), 32'(mon_e.to));
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic run_round(input vec_t v, input string tag, output int first_go);
      int   cd;
      int   p;
      int   c;
      int   go_cnt;
      int   done_at;
      int   exp_done;
      exp_t e;
      cd = D;
`ifdef PRESS_REFEREE_RANDOM_DELAY_EN
      cd = D + int'(lfsr_m[2:0]);
`endif
      p        = v.in_go ? cd + v.off : v.off;
      exp_done = v.exp_to ? cd + T : p;
      first_go = -1;
      go_cnt   = 0;
      done_at  = -1;
      c        = 0;
      start    = 1'b1;
      press    = (p == 0) ? v.pv : '0;
      tick();
      start   = v.hold_start;
      press   = '0;
      e.win   = v.exp_win;
      e.foul  = v.exp_foul;
      e.to    = v.exp_to;
      sb.push_back(e);
      chk({tag, "_busy_started"}, 32'(busy), 32'd1);
      chk({tag, "_cleared_winner"}, 32'(winner), 32'd0);
      chk({tag, "_cleared_foul_timeout"}, 32'({foul, timeout}), 32'd0);
      while (done_at < 0 && c < 400) begin
         press = (c + 1 == p) ? v.pv : '0;
         tick();
         c++;
         press = '0;
         if (go) begin
            go_cnt++;
            if (first_go < 0) first_go = c;
         end
         if (round_done) done_at = c;
      end
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
      chk({tag, "_go_cycles"}, 32'(go_cnt), 32'(v.exp_go));
      if (v.exp_go > 0) chk({tag, "_go_rise"}, 32'(first_go), 32'(cd));
      tick();
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_done_one_pulse"}, 32'(round_done), 32'd0);
      chk({tag, "_winner_held"}, 32'(winner), 32'(v.exp_win));
      chk({tag, "_foul_held"}, 32'(foul), 32'(v.exp_foul));
      chk({tag, "_timeout_held"}, 32'(timeout), 32'(v.exp_to));
      start = 1'b0;
   endtask

   initial begin
      int c;
      int go_cnt;
      vecs[0]  = '{1'b1,  3, 2'b10, 1'b0, 2'b10, 2'b00, 1'b0,  3};
      vecs[1]  = '{1'b0,  4, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0,  0};
      vecs[2]  = '{1'b1,  1, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0,  1};
      vecs[3]  = '{1'b1,  1, 2'b11, 1'b0, 2'b10, 2'b00, 1'b0,  1};
      vecs[4]  = '{1'b1,  1, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0,  1};
      vecs[5]  = '{1'b0,  0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 64};
      vecs[6]  = '{1'b0,  8, 2'b11, 1'b0, 2'b00, 2'b11, 1'b0,  0};
      vecs[7]  = '{1'b0,  0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 64};
      vecs[8]  = '{1'b1, 64, 2'b11, 1'b0, 2'b10, 2'b00, 1'b0, 64};
      vecs[9]  = '{1'b1,  2, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0,  2};
      vecs[10] = '{1'b1,  2, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0,  2};

      reset = 1'b1;
      start = 1'b0;
      press = '0;
      repeat (2) tick();
      chk("rst_go", 32'(go), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_foul", 32'(foul), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_round_done", 32'(round_done), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_round(vecs[i], $sformatf("v%0d", i), fg);
      end

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("idle_rst_winner", 32'(winner), 32'd0);
      chk("idle_rst_busy", 32'(busy), 32'd0);

      run_round('{1'b1, 1, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1}, "pre_reset", fg);

      start = 1'b1;
      tick();
      start  = 1'b0;
      c      = 0;
      go_cnt = 0;
      while (go_cnt < 5 && c < 200) begin
         tick();
         c++;
         if (go) go_cnt++;
      end
      chk("midreset_reached_go5", 32'(go_cnt), 32'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset_go", 32'(go), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_results", 32'({winner, foul, timeout}), 32'd0);
      chk("midreset_round_done", 32'(round_done), 32'd0);
      repeat (3) begin
         tick();
         chk("midreset_quiet", 32'({busy, round_done}), 32'd0);
      end

      run_round('{1'b1, 1, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1}, "ptr_after_reset", fg);

`ifdef PRESS_REFEREE_RANDOM_DELAY_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      run_round('{1'b1, 1, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1}, "rnd_a", fg);
      chk("rnd_a_holdoff", 32'(fg), 32'd8);
      c = 0;
      while (lfsr_m[2:0] != 3'd5 && c < 300) begin
         tick();
         c++;
      end
      run_round('{1'b1, 1, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1}, "rnd_b", fg);
      chk("rnd_b_holdoff", 32'(fg), 32'd13);
`endif

      tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
